// File: rtl/msbs_t3_seq.sv
`default_nettype none
// ============================================================================
// Module   : msbs_t3_seq
// Brief    : Sequential t=3 modified-SBS error-locator coefficient generator.
//            One shared GF(2^10) multiplier is stepped through 8 products.
// Revision : 1.0 - initial release
// ============================================================================
module msbs_t3_seq #(
    parameter int                GF_LEN    = 10,
    parameter logic [GF_LEN:0]   PRIM_POLY = 11'h409
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [GF_LEN-1:0] synd1,
    input  logic [GF_LEN-1:0] synd3,
    input  logic [GF_LEN-1:0] synd5,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [GF_LEN-1:0] out_deg2_R,
    output logic [GF_LEN-1:0] out_deg3_A,
    output logic [GF_LEN-1:0] out_deg3_B,
    output logic [GF_LEN-1:0] out_deg3_C,
    output logic [GF_LEN-1:0] out_deg3_R,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Shift-and-add GF multiply; each shift of the multiplicand is reduced
    // by the primitive polynomial so the accumulator never exceeds GF_LEN bits.
    function automatic logic [GF_LEN-1:0] gf_mul(
        input logic [GF_LEN-1:0] a,
        input logic [GF_LEN-1:0] b
    );
        logic [GF_LEN-1:0] acc;
        logic [GF_LEN-1:0] sh;
        acc = '0;
        sh  = a;
        for (int i = 0; i < GF_LEN; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = {sh[GF_LEN-2:0], 1'b0} ^ (sh[GF_LEN-1] ? PRIM_POLY[GF_LEN-1:0] : '0);
        end
        return acc;
    endfunction

    state_t            r_state;
    state_t            w_state_nxt;
    logic [2:0]        r_step;

    logic [GF_LEN-1:0] r_s1, r_s3, r_s5;
    logic [GF_LEN-1:0] r_p2, r_p3, r_p4, r_s1s3, r_s1s5, r_p2s3, r_p3s3;
    logic [GF_LEN-1:0] r_deg2_r, r_deg3_a, r_deg3_b, r_deg3_c, r_deg3_r;
    logic              r_out_valid;

    logic [GF_LEN-1:0] w_op_a, w_op_b, w_prod, w_t;
    logic              w_accept;
    logic              w_last;

    assign in_ready = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
    assign w_accept = in_valid && in_ready;
    assign w_last   = (r_state == S_CALC) && (r_step == 3'd7);
    assign w_t      = r_p3 ^ r_s3;

    assign out_valid  = r_out_valid;
    assign busy       = (r_state == S_CALC);
    assign out_deg2_R = r_deg2_r;
    assign out_deg3_A = r_deg3_a;
    assign out_deg3_B = r_deg3_b;
    assign out_deg3_C = r_deg3_c;
    assign out_deg3_R = r_deg3_r;

    // Operand select for the shared multiplier, indexed by the product step.
    always_comb begin
        w_op_a = r_s1;
        w_op_b = r_s1;
        case (r_step)
            3'd0: begin w_op_a = r_s1; w_op_b = r_s1; end
            3'd1: begin w_op_a = r_p2; w_op_b = r_s1; end
            3'd2: begin w_op_a = r_p2; w_op_b = r_p2; end
            3'd3: begin w_op_a = r_s1; w_op_b = r_s3; end
            3'd4: begin w_op_a = r_s1; w_op_b = r_s5; end
            3'd5: begin w_op_a = r_p2; w_op_b = r_s3; end
            3'd6: begin w_op_a = r_p3; w_op_b = r_s3; end
            default: begin w_op_a = w_t; w_op_b = w_t; end
        endcase
    end

    assign w_prod = gf_mul(w_op_a, w_op_b);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic: DONE may hand straight back to CALC when a new set
    // arrives on the same edge the current result is consumed.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = S_CALC;
            S_CALC: if (r_step == 3'd7) w_state_nxt = S_DONE;
            S_DONE: if (out_ready) w_state_nxt = in_valid ? S_CALC : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Syndrome capture, step counter and product/intermediate registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_step   <= 3'd0;
            r_s1     <= '0;
            r_s3     <= '0;
            r_s5     <= '0;
            r_p2     <= '0;
            r_p3     <= '0;
            r_p4     <= '0;
            r_s1s3   <= '0;
            r_s1s5   <= '0;
            r_p2s3   <= '0;
            r_p3s3   <= '0;
        end else if (w_accept) begin
            r_step <= 3'd0;
            r_s1   <= synd1;
            r_s3   <= synd3;
            r_s5   <= synd5;
        end else if (r_state == S_CALC) begin
            r_step <= r_step + 3'd1;
            case (r_step)
                3'd0: r_p2   <= w_prod;
                3'd1: r_p3   <= w_prod;
                3'd2: r_p4   <= w_prod;
                3'd3: r_s1s3 <= w_prod;
                3'd4: r_s1s5 <= w_prod;
                3'd5: r_p2s3 <= w_prod;
                3'd6: r_p3s3 <= w_prod;
                default: ;
            endcase
        end
    end

    // Coefficient outputs load together on the final step and hold afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_deg2_r <= '0;
            r_deg3_a <= '0;
            r_deg3_b <= '0;
            r_deg3_c <= '0;
            r_deg3_r <= '0;
        end else if (w_last) begin
            r_deg2_r <= w_t;
            r_deg3_c <= w_t;
            r_deg3_a <= r_p2s3 ^ r_s5;
            r_deg3_b <= r_s1s3 ^ r_p4;
            r_deg3_r <= r_s1s5 ^ r_p3s3 ^ w_prod;
        end
    end

    // Output-valid flag: set on the final step, cleared when consumed.
    always_ff @(posedge clk) begin
        if (rst)                                 r_out_valid <= 1'b0;
        else if (w_last)                         r_out_valid <= 1'b1;
        else if ((r_state == S_DONE) && out_ready) r_out_valid <= 1'b0;
    end

endmodule
`default_nettype wire

// File: tb/tb_msbs_t3_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_msbs_t3_seq
// Brief    : Scoreboard bench for msbs_t3_seq with directed syndrome vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_msbs_t3_seq;

    typedef struct {
        logic [9:0] r2;
        logic [9:0] a;
        logic [9:0] b;
        logic [9:0] c;
        logic [9:0] r3;
        int         acc;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [9:0] synd1, synd3, synd5;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] out_deg2_R, out_deg3_A, out_deg3_B, out_deg3_C, out_deg3_R;
    logic       busy;

    exp_t q[$];
    int   n_vec;
    int   n_err;
    int   cyc;
    logic prev_valid;

    msbs_t3_seq dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .synd1      (synd1),
        .synd3      (synd3),
        .synd5      (synd5),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_deg2_R (out_deg2_R),
        .out_deg3_A (out_deg3_A),
        .out_deg3_B (out_deg3_B),
        .out_deg3_C (out_deg3_C),
        .out_deg3_R (out_deg3_R),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: latency check on each rising out_valid, scoreboard pop on transfer.
    initial prev_valid = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (out_valid && !prev_valid) begin
                if (q.size() == 0) chk("unexpected_valid", 1, 0);
                else               chk("latency", cyc - q[0].acc, 8);
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("scoreboard_empty", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("deg2_R", out_deg2_R, e.r2);
                    chk("deg3_A", out_deg3_A, e.a);
                    chk("deg3_B", out_deg3_B, e.b);
                    chk("deg3_C", out_deg3_C, e.c);
                    chk("deg3_R", out_deg3_R, e.r3);
                end
            end
            prev_valid = out_valid;
        end
    end

    // Present a syndrome set until accepted; returns just after the accept edge.
    task automatic issue(input logic [9:0] s1, input logic [9:0] s3, input logic [9:0] s5,
                         input logic [9:0] r2, input logic [9:0] a, input logic [9:0] b,
                         input logic [9:0] r3);
        exp_t e;
        bit   ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        synd1    = s1;
        synd3    = s3;
        synd5    = s5;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            @(posedge clk);
        end
        #1;
        in_valid = 1'b0;
        synd1    = 10'h3FF;
        synd3    = 10'h3FF;
        synd5    = 10'h3FF;
        if (!ok) begin
            chk("accept_timeout", 0, 1);
        end else begin
            e.r2 = r2; e.a = a; e.b = b; e.c = r2; e.r3 = r3; e.acc = cyc;
            q.push_back(e);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && q.size() != 0; i++) @(posedge clk);
        #1;
        chk("drain_queue_empty", q.size(), 0);
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        synd1     = '0;
        synd3     = '0;
        synd5     = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_deg3_R", out_deg3_R, 0);
        @(posedge clk);
        #1;

        // Directed vectors with free-flowing downstream.
        issue(10'h001, 10'h001, 10'h001, 10'h000, 10'h000, 10'h000, 10'h000);
        @(negedge clk);
        chk("busy_in_calc", busy, 1);
        chk("in_ready_in_calc", in_ready, 0);
        @(posedge clk); #1;
        issue(10'h000, 10'h001, 10'h002, 10'h001, 10'h002, 10'h000, 10'h001);
        issue(10'h002, 10'h000, 10'h000, 10'h008, 10'h000, 10'h010, 10'h040);
        issue(10'h200, 10'h000, 10'h000, 10'h0C8, 10'h000, 10'h344, 10'h0F4);
        drain();

        // Backpressure: hold the result in DONE for 5 cycles.
        @(posedge clk); #1;
        out_ready = 1'b0;
        issue(10'h002, 10'h000, 10'h000, 10'h008, 10'h000, 10'h010, 10'h040);
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clk);
                if (out_valid) seen = 1'b1;
            end
            chk("bp_valid_seen", seen, 1);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_deg2_R", out_deg2_R, 10'h008);
            chk("bp_deg3_B", out_deg3_B, 10'h010);
            chk("bp_deg3_R", out_deg3_R, 10'h040);
        end
        // Consume and accept on the same edge.
        @(posedge clk); #1;
        out_ready = 1'b1;
        issue(10'h200, 10'h000, 10'h000, 10'h0C8, 10'h000, 10'h344, 10'h0F4);
        @(negedge clk);
        chk("simul_busy", busy, 1);
        chk("simul_out_valid", out_valid, 0);
        drain();

        // Reset in the middle of CALC (during step 4).
        @(posedge clk); #1;
        issue(10'h000, 10'h001, 10'h002, 10'h001, 10'h002, 10'h000, 10'h001);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_deg2_R", out_deg2_R, 0);
        chk("midrst_deg3_B", out_deg3_B, 0);
        chk("midrst_deg3_R", out_deg3_R, 0);
        @(posedge clk); #1;
        issue(10'h002, 10'h000, 10'h000, 10'h008, 10'h000, 10'h010, 10'h040);
        drain();

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/msbs_t3_seq.md
Name: msbs_t3_seq

Overview:
- Multi-cycle, area-reduced generator of the t=3 modified-SBS (mSBS) error-locator coefficients.
- Sequences a single shared GF(2^10) multiplier through 8 product steps instead of instantiating one multiplier per product.
- Sits between the syndrome calculator and the Chien search. Uses a valid/ready handshake on both sides.

Parameters:
- GF_LEN, 10, field width. Only 10 is supported.
- PRIM_POLY, 11'h409, field primitive polynomial x^10+x^3+1 used by the internal multiplier.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  syndrome set valid
- in_ready  output  1  block can accept a syndrome set this cycle
- synd1  input  GF_LEN  S1
- synd3  input  GF_LEN  S3
- synd5  input  GF_LEN  S5
- out_valid  output  1  coefficient set valid
- out_ready  input  1  downstream accepts the coefficient set
- out_deg2_R  output  GF_LEN  S1^3+S3
- out_deg3_A  output  GF_LEN  S1^2·S3+S5
- out_deg3_B  output  GF_LEN  S1·S3+S1^4
- out_deg3_C  output  GF_LEN  S1^3+S3
- out_deg3_R  output  GF_LEN  S1·S5+S1^3·S3+(S1^3+S3)^2
- busy  output  1  state==CALC

Behaviour:
- Arithmetic and registers:
  - All arithmetic is in GF(2^10): addition is XOR; multiplication uses one combinational multiplier reduced modulo PRIM_POLY.
  - Intermediate registers: p2, p3, p4, s1s3, s1s5, p2s3, p3s3.
- States: IDLE, CALC, DONE. There is a 3-bit step counter `step`.
- Handshake:
  - in_ready = (state==IDLE) | (state==DONE & out_ready).
  - Accept = in_valid & in_ready.
  - On accept: S1/S3/S5 are registered, state goes to CALC, step=0.
  - Input pins are ignored outside the accept edge.
- CALC: one multiplication per cycle; the product is written at the end of the cycle, then step increments.
  - step0: p2=S1·S1
  - step1: p3=p2·S1
  - step2: p4=p2·p2
  - step3: s1s3=S1·S3
  - step4: s1s5=S1·S5
  - step5: p2s3=p2·S3
  - step6: p3s3=p3·S3
  - step7: multiplier operand t=p3^S3, product tp2=t·t. On this edge all outputs load together:
    - deg2_R=t, deg3_C=t
    - deg3_A=p2s3^S5
    - deg3_B=s1s3^p4
    - deg3_R=s1s5^p3s3^tp2
    - out_valid←1, state←DONE
- Latency: out_valid rises 8 cycles after the accept edge.
- DONE:
  - Outputs and out_valid hold stable while out_ready=0.
  - out_ready=1 & in_valid=0: out_valid←0, state←IDLE. Outputs retain their last values.
  - out_ready=1 & in_valid=1 (simultaneous): the output set is consumed and the new set is accepted on the same edge; state←CALC, out_valid←0.
  - Minimum period between accepts is 9 cycles.
- Zero syndromes need no special-casing; the arithmetic naturally yields zeros.
- Reset (any state, including mid-CALC):
  - state=IDLE, step=0.
  - All intermediate and output registers = 0; out_valid=0, busy=0.
  - Any in-flight computation is discarded.
- A new syndrome set is never accepted during CALC, since in_ready=0 there.

Test Plan:
- Reset, then accept S1=0x001, S3=0x001, S5=0x001 -> after 8 cycles out_valid=1 with all five outputs 0x000.
- S1=0x000, S3=0x001, S5=0x002 -> deg2_R=0x001, A=0x002, B=0x000, C=0x001, R=0x001.
- S1=0x002, S3=0, S5=0 -> deg2_R=0x008, A=0x000, B=0x010, C=0x008, R=0x040.
- S1=0x200, S3=0, S5=0 (exercises reduction) -> deg2_R=C=0x0C8, A=0x000, B=0x344, R=0x0F4.
- Backpressure and simultaneous events:
  - Hold out_ready=0 for 5 cycles in DONE -> outputs stable and in_ready=0.
  - Then raise out_ready with in_valid=1 -> consume and accept on the same edge; next result arrives 8 cycles later.
- Assert rst at step 4 of CALC -> next cycle: IDLE, out_valid=0, outputs 0, in_ready=1. A fresh accept then completes normally.
